// File: rtl/npu_conv_pkg.sv
// Shared types and default geometry for the convolution window sequencer.
package npu_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        GAP   = 2'd2,
        FLUSH = 2'd3
    } win_state_e;

    localparam int IMG_H_DEF = 5;
    localparam int IMG_W_DEF = 5;
    localparam int K_H_DEF   = 3;
    localparam int K_W_DEF   = 3;

    // Number of output positions along one axis for stride 1.
    function automatic int out_count(input int img, input int k);
        return img - k + 1;
    endfunction

endpackage

// File: rtl/conv_window_ctrl.sv
// Sliding-window sequencer: walks K_H-row bands of the image one column per
// cycle, drives the window register's clear/load and tags each full window.
module conv_window_ctrl
    import npu_conv_pkg::*;
#(
    parameter int IMG_H = IMG_H_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int K_H   = K_H_DEF,
    parameter int K_W   = K_W_DEF,
    parameter int RW    = $clog2(IMG_H),
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          img_rd_en,
    output logic [RW-1:0] img_rd_row,
    output logic [CW-1:0] img_rd_col,
    output logic          win_load_en,
    output logic          win_clear,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col
);

    localparam int LAST_ROW = out_count(IMG_H, K_H) - 1;
    localparam int LAST_COL = IMG_W - 1;
    localparam int FULL_COL = K_W - 1;

    win_state_e    state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          busy_q;
    logic          done_q;
    logic          abort_clr;
    logic          rd_en;

    logic          ld_en;
    logic [RW-1:0] ld_row;
    logic [CW-1:0] ld_col;
    logic          vld;
    logic [RW-1:0] v_row;
    logic [CW-1:0] v_col;

    // Read issue follows hold in the same cycle so a held column (and its
    // clear) is simply deferred; the counters stay put meanwhile.
    assign rd_en       = (state == RUN) && !hold;
    assign img_rd_en   = rd_en;
    assign img_rd_row  = row;
    assign img_rd_col  = col;
    assign win_clear   = (rd_en && (col == '0)) || abort_clr;
    assign win_load_en = ld_en;
    assign win_valid   = vld;
    assign win_row     = v_row;
    assign win_col     = v_col;
    assign busy        = busy_q;
    assign done        = done_q;

    // Scan FSM with row/column counters; abort from any busy state wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_clr <= 1'b0;
        end else begin
            abort_clr <= 1'b0;
            if (state != IDLE && abort) begin
                state     <= IDLE;
                row       <= '0;
                col       <= '0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                abort_clr <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!hold) begin
                            if (col == CW'(LAST_COL)) begin
                                col   <= '0;
                                state <= GAP;
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (row == RW'(LAST_ROW)) begin
                            state  <= FLUSH;
                            done_q <= 1'b1;
                        end else begin
                            row   <= row + RW'(1);
                            state <= RUN;
                        end
                    end
                    FLUSH: begin
                        state  <= IDLE;
                        row    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Two-stage tag pipeline: read -> load into window register -> window valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_en  <= 1'b0;
            ld_row <= '0;
            ld_col <= '0;
            vld    <= 1'b0;
            v_row  <= '0;
            v_col  <= '0;
        end else begin
            ld_en  <= rd_en && !abort;
            ld_row <= row;
            ld_col <= col;
            vld    <= ld_en && (ld_col >= CW'(FULL_COL)) && !abort;
            if (ld_en && (ld_col >= CW'(FULL_COL))) begin
                v_row <= ld_row;
                v_col <= ld_col - CW'(FULL_COL);
            end
        end
    end

endmodule
